vend_ctrl: RTL



---
 rtl/vend_pkg.sv | 31 +++
 rtl/vend_ctrl_if.sv | 37 +++
 rtl/vend_change_sel.sv | 24 ++
 rtl/vend_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin codes, controller states and shared helpers for vend_ctrl
package vend_pkg;

   typedef enum logic [1:0] {
      COIN_1  = 2'b00,
      COIN_2  = 2'b01,
      COIN_5  = 2'b10,
      COIN_10 = 2'b11
   } coin_code_e;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      VEND    = 2'd1,
      CHANGE  = 2'd2
   } state_e;

   function automatic logic [3:0] coin_value(input logic [1:0] code);
      case (coin_code_e'(code))
         COIN_1:  return 4'd1;
         COIN_2:  return 4'd2;
         COIN_5:  return 4'd5;
         default: return 4'd10;
      endcase
   endfunction

   // Selection index width; a single-product machine still carries a 1-bit id.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// rtl/vend_ctrl_if.sv - coin/selection/change bundle between front end and vend_ctrl
interface vend_ctrl_if
   import vend_pkg::*;
#(
   parameter int NUM_PROD = 4,
   parameter int CREDIT_W = 8
);
   localparam int SEL_W = sel_w(NUM_PROD);

   logic                coin_valid;
   logic [1:0]          coin_code;
   logic                sel_valid;
   logic [SEL_W-1:0]    sel_id;
   logic                cancel;
   logic                change_ready;
   logic [CREDIT_W-1:0] credit;
   logic                vend_valid;
   logic [SEL_W-1:0]    vend_id;
   logic                coin_reject;
   logic                sel_deny;
   logic                change_valid;
   logic [1:0]          change_code;
   logic                busy;

   modport master (
      output coin_valid, coin_code, sel_valid, sel_id, cancel, change_ready,
      input  credit, vend_valid, vend_id, coin_reject, sel_deny,
             change_valid, change_code, busy
   );

   modport slave (
      input  coin_valid, coin_code, sel_valid, sel_id, cancel, change_ready,
      output credit, vend_valid, vend_id, coin_reject, sel_deny,
             change_valid, change_code, busy
   );

endinterface

// File: rtl/vend_change_sel.sv
// rtl/vend_change_sel.sv - picks the largest coin denomination not exceeding the credit
module vend_change_sel
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8
) (
   input  logic [CREDIT_W-1:0] i_credit,
   output logic [1:0]          o_code,
   output logic [3:0]          o_value
);

   always_comb begin
      o_code = COIN_1;
      if (i_credit >= CREDIT_W'(10))
         o_code = COIN_10;
      else if (i_credit >= CREDIT_W'(5))
         o_code = COIN_5;
      else if (i_credit >= CREDIT_W'(2))
         o_code = COIN_2;
   end

   assign o_value = coin_value(o_code);

endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - multi-product vending controller: credit, vend pulse, change payout.
// VEND_MULTI_CHANGE_EN selects largest-denomination change beats instead of 1-unit beats.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int                           NUM_PROD   = 4,
   parameter int                           CREDIT_W   = 8,
   parameter int                           MAX_CREDIT = 200,
   parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES     = {8'd25, 8'd20, 8'd15, 8'd10}
) (
   input logic        clk,
   input logic        rst,
   vend_ctrl_if.slave bus
);
   localparam int SEL_W = sel_w(NUM_PROD);

   state_e              r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [SEL_W-1:0]    r_vend_id;
   logic                r_coin_reject;
   logic                r_sel_deny;

   logic [CREDIT_W:0]   w_coin_sum;
   logic                w_coin_fits;
   logic [CREDIT_W-1:0] w_price;
   logic                w_sel_accept;
   logic                w_cancel_accept;
   logic [CREDIT_W-1:0] w_beat_val;
   logic [1:0]          w_beat_code;

   // One extra bit so the MAX_CREDIT compare can never be fooled by wrap-around.
   assign w_coin_sum  = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value(bus.coin_code));
   assign w_coin_fits = (w_coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

   always_comb begin
      w_price = '0;
      for (int i = 0; i < NUM_PROD; i++)
         if (bus.sel_id == SEL_W'(i))
            w_price = PRICES[i*CREDIT_W +: CREDIT_W];
   end

   assign w_sel_accept    = (int'(bus.sel_id) < NUM_PROD) && (r_credit >= w_price);
   assign w_cancel_accept = bus.cancel && (r_credit != '0);

`ifdef VEND_MULTI_CHANGE_EN
   logic [1:0] w_pick_code;
   logic [3:0] w_pick_value;

   vend_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
      .i_credit (r_credit),
      .o_code   (w_pick_code),
      .o_value  (w_pick_value)
   );

   assign w_beat_val  = CREDIT_W'(w_pick_value);
   assign w_beat_code = w_pick_code;
`else
   assign w_beat_val  = CREDIT_W'(1);
   assign w_beat_code = 2'b00;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= COLLECT;
         r_credit      <= '0;
         r_vend_id     <= '0;
         r_coin_reject <= 1'b0;
         r_sel_deny    <= 1'b0;
      end else begin
         r_coin_reject <= 1'b0;
         r_sel_deny    <= 1'b0;
         case (r_state)
            COLLECT: begin
               if (w_cancel_accept) begin
                  r_state       <= CHANGE;
                  r_coin_reject <= bus.coin_valid;
               end else if (bus.sel_valid && w_sel_accept) begin
                  r_credit      <= r_credit - w_price;
                  r_vend_id     <= bus.sel_id;
                  r_state       <= VEND;
                  r_coin_reject <= bus.coin_valid;
               end else begin
                  // Denied selections and no-credit cancels leave the coin path untouched.
                  r_sel_deny <= bus.sel_valid;
                  if (bus.coin_valid) begin
                     if (w_coin_fits)
                        r_credit <= w_coin_sum[CREDIT_W-1:0];
                     else
                        r_coin_reject <= 1'b1;
                  end
               end
            end
            VEND: begin
               r_coin_reject <= bus.coin_valid;
               r_state       <= (r_credit != '0) ? CHANGE : COLLECT;
            end
            CHANGE: begin
               r_coin_reject <= bus.coin_valid;
               if (bus.change_ready) begin
                  r_credit <= r_credit - w_beat_val;
                  if (r_credit == w_beat_val)
                     r_state <= COLLECT;
               end
            end
            default: r_state <= COLLECT;
         endcase
      end
   end

   assign bus.credit       = r_credit;
   assign bus.vend_valid   = (r_state == VEND);
   assign bus.vend_id      = r_vend_id;
   assign bus.coin_reject  = r_coin_reject;
   assign bus.sel_deny     = r_sel_deny;
   assign bus.change_valid = (r_state == CHANGE);
   assign bus.change_code  = (r_state == CHANGE) ? w_beat_code : 2'b00;
   assign bus.busy         = (r_state != COLLECT);

endmodule
